exu_lsu: RTL and testbench
==========================

Name: exu_lsu

Overview:
Load/store stage directly downstream of the execute ALU. It consumes the ALU's memory request (wen/ren, address, store data), its result and its rd write-back info. It runs the data-bus transaction with a req/gnt/rvalid handshake, aligns and extends load data, and presents one registered write-back beat per instruction. It stalls upstream through o_ready while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ+WAIT_R before the access is aborted with o_bus_err (min 2).

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  instruction from execute valid
o_ready  output  1  stage can accept (1 only in IDLE)
i_mem_wen  input  1  store request
i_mem_ren  input  1  load request
i_mem_addr  input  32  byte address
i_mem_wdata  input  32  store data (rs2), unaligned
i_funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
i_alu_result  input  32  ALU result for non-memory instructions
i_rd_wen  input  1  rd write enable
i_rd_addr  input  5  rd index
o_bus_req  output  1  bus request
o_bus_we  output  1  1=write
o_bus_addr  output  32  word address ({addr[31:2],2'b00})
o_bus_be  output  4  byte enables
o_bus_wdata  output  32  lane-replicated store data
i_bus_gnt  input  1  request accepted
i_bus_rvalid  input  1  read data valid
i_bus_rdata  input  32  read data word
o_wb_valid  output  1  write-back beat (1-cycle pulse)
o_wb_rd_wen  output  1  write rd
o_wb_rd_addr  output  5  rd index
o_wb_data  output  32  write-back data
o_misalign  output  1  misaligned or illegal-size access (pulse with o_wb_valid)
o_bus_err  output  1  bus timeout (pulse with o_wb_valid)

Behaviour:
- The interface has one clock. Reset is synchronous and active-high.
- States: IDLE, REQ, WAIT_R. Reset puts the FSM in IDLE and clears the timeout counter. Reset values: o_bus_req, o_bus_we, o_wb_valid, o_wb_rd_wen, o_misalign and o_bus_err are 0; o_bus_addr, o_bus_be, o_bus_wdata, o_wb_data and o_wb_rd_addr are 0. o_ready is 1 after reset.
- Accept rule: a transfer is accepted when i_valid && o_ready. The stage latches addr, funct3, wdata, rd info and alu result. Outputs are registered.
- Non-memory instruction (wen=ren=0): next cycle o_wb_valid=1, o_wb_data=i_alu_result, o_wb_rd_wen=i_rd_wen. FSM stays in IDLE, so back-to-back throughput is 1 per cycle.
- If wen and ren are both 1, the access is treated as a store.
- Misalign check at accept:
  - h with addr[0]=1 is misaligned.
  - w with addr[1:0]!=0 is misaligned.
  - funct3 011/110/111 on a memory op is illegal, and so is any store with funct3[2]=1.
  - Result: no bus request. Next cycle o_wb_valid=1, o_misalign=1, o_wb_rd_wen=0. FSM stays in IDLE.
- Valid memory op: FSM goes to REQ. o_bus_req=1 starting the cycle after accept and is held, with addr/we/be/wdata stable, until the cycle i_bus_gnt=1.
- Store lanes and enables:
  - Store b: be=1<<addr[1:0], wdata={4{byte}}.
  - Store h: be=addr[1]?1100:0011, wdata={2{half}}.
  - Store w: be=1111.
  - Load: be follows the same size rule; o_bus_we=0.
- Store on gnt cycle: req drops next cycle. Also next cycle: o_wb_valid=1, o_wb_rd_wen=0, FSM back to IDLE.
- Load on gnt cycle: FSM goes to WAIT_R and req drops. i_bus_rvalid is honoured only in WAIT_R; its earliest arrival is the cycle after gnt. On rvalid the stage aligns the data (rdata>>(8*addr[1:0])) and sign- or zero-extends it per funct3. Next cycle: o_wb_valid=1, o_wb_data=extended value, o_wb_rd_wen=i_rd_wen, FSM back to IDLE.
- A load to rd=x0 still performs the bus read. o_wb_rd_wen passes through unchanged; the register file ignores x0.
- Timeout: the counter clears on accept and increments each cycle in REQ or WAIT_R. When it reaches TIMEOUT_CYCLES:
  - req drops.
  - Next cycle: o_wb_valid=1, o_bus_err=1, o_wb_rd_wen=0.
  - FSM returns to IDLE.
  - A gnt or rvalid arriving on the same cycle as the timeout takes precedence over it.
- rvalid in IDLE or REQ is ignored. gnt when req=0 is ignored.
- o_ready=0 in REQ and WAIT_R. Upstream holds its inputs stable.
- Reset mid-transaction: on the next edge req=0 and the FSM is in IDLE. There is no write-back for the aborted op, and a late rvalid is ignored.

Test Plan:
- Non-memory: alu_result=0x0000_1234, rd=5 with wen, 3 back-to-back → three o_wb_valid pulses on consecutive cycles, data 0x1234, rd 5, no bus req.
- sb addr=0x1003 wdata=0xAABBCC7F, gnt after 2 wait cycles → req held 3 cycles, bus_addr 0x1000, be 1000, wdata 0x7F7F7F7F; wb pulse with rd_wen=0 the cycle after gnt.
- lb and lbu at addr=0x2002, rdata=0x1280_3456, rvalid 3 cycles after gnt → lb wb_data 0xFFFF_FF80; lbu wb_data 0x0000_0080; lh at 0x2002 gives 0x0000_1280.
- lw addr=0x3001 → no req; next cycle o_wb_valid=1, o_misalign=1, rd_wen=0; o_ready stays 1.
- TIMEOUT_CYCLES=4, load with gnt never asserted → req high 4 cycles then drops; next cycle o_bus_err=1, wb_valid=1, rd_wen=0. A late rvalid afterwards is ignored.
- Reset asserted in WAIT_R followed by rvalid → req=0, no wb_valid, and o_ready=1 after the reset edge.

Source files
------------

// File: rtl/exu_lsu_if.sv
// exu_lsu_if: data-bus interface between the load/store stage and memory.
//
// Signals:
//   req     - bus request, held until gnt
//   we      - 1 = write, 0 = read
//   addr    - word-aligned byte address
//   be      - byte enables
//   wdata   - lane-replicated store data
//   gnt     - request accepted
//   rvalid  - read data valid
//   rdata   - read data word
//
// Modports: master (the load/store stage), slave (the memory side).

interface exu_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/exu_lsu.sv
// exu_lsu: load/store stage that sits after the execute ALU.
//
// This stage takes one instruction from execute and produces one registered
// write-back beat for it:
//   - Non-memory ops go straight to write-back on the next cycle.
//   - Misaligned accesses and illegal sizes also go straight to write-back on
//     the next cycle, with o_misalign set.
//   - Legal loads and stores run a bus transaction using req/gnt/rvalid.
//     o_ready stays low until that transaction is finished.
// If the access takes too long in REQ plus WAIT_R, it is aborted with
// o_bus_err.
//
// Ports:
//   i_clk, i_rst         - clock, synchronous active-high reset
//   i_valid / o_ready    - handshake with execute
//   i_mem_wen/ren        - store/load request (both set = store)
//   i_mem_addr           - byte address
//   i_mem_wdata          - store data (unaligned)
//   i_funct3             - access size/sign
//   i_alu_result         - result for non-memory ops
//   i_rd_wen, i_rd_addr  - destination register info
//   bus                  - data bus (exu_lsu_if.master)
//   o_wb_*               - write-back beat
//   o_misalign           - misaligned/illegal access flag (with o_wb_valid)
//   o_bus_err            - bus timeout flag (with o_wb_valid)

module exu_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_wen,
    input  logic        i_mem_ren,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd_addr,
    exu_lsu_if.master   bus,
    output logic        o_wb_valid,
    output logic        o_wb_rd_wen,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_data,
    output logic        o_misalign,
    output logic        o_bus_err
);

    // The counter has to be able to hold TIMEOUT_CYCLES.
    // That value is reached when a grant arrives on the last REQ cycle.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            rd_wen_q, rd_wen_d;
    logic            ready_q, ready_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_rd_wen_q, wb_rd_wen_d;
    logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;

    logic            is_mem;
    logic            is_store;
    logic            bad_access;
    logic [3:0]      be_calc;
    logic [31:0]     wdata_calc;
    logic            timeout_hit;

    // Shift the addressed byte/half down to bit 0, then extend it by funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [31:0] s;
        s = word >> {lo, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
            3'b100:  load_extend = {24'h0, s[7:0]};
            3'b101:  load_extend = {16'h0, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    // Decode the incoming request: find the lane enables and the replicated
    // store data, and decide whether the access is misaligned or illegal.
    always_comb begin
        is_mem   = i_mem_wen | i_mem_ren;
        is_store = i_mem_wen;
        case (i_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << i_mem_addr[1:0];
                wdata_calc = {4{i_mem_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{i_mem_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = i_mem_wdata;
            end
        endcase
        bad_access = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                     (i_funct3 == 3'b111) || (is_store && i_funct3[2]) ||
                     ((i_funct3[1:0] == 2'b01) && i_mem_addr[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_mem_addr[1:0] != 2'b00));
    end

    // The timeout counter covers the time spent in REQ and in WAIT_R together.
    assign timeout_hit = (cnt_q >= CNT_LAST);

    // Next-state and next-output logic.
    // A gnt or rvalid in the cycle is checked before the timeout, so it wins
    // when both happen in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        rd_wen_d     = rd_wen_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_wen_d  = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_data_d    = wb_data_q;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    cnt_d        = '0;
                    addr_lo_d    = i_mem_addr[1:0];
                    funct3_d     = i_funct3;
                    rd_wen_d     = i_rd_wen;
                    wb_rd_addr_d = i_rd_addr;
                    if (!is_mem) begin
                        wb_valid_d  = 1'b1;
                        wb_rd_wen_d = i_rd_wen;
                        wb_data_d   = i_alu_result;
                    end else if (bad_access) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d     = REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {i_mem_addr[31:2], 2'b00};
                        bus_be_d    = be_calc;
                        bus_wdata_d = wdata_calc;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    wb_data_d  = '0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.rvalid) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_rd_wen_d = rd_wen_q;
                    wb_data_d   = load_extend(bus.rdata, addr_lo_q, funct3_q);
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    wb_data_d  = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // All state and outputs are registered here.
    // Reset drops any transaction in flight and does not produce a write-back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
            rd_wen_q     <= 1'b0;
            ready_q      <= 1'b1;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_wen_q  <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            rd_wen_q     <= rd_wen_d;
            ready_q      <= ready_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_wen_q  <= wb_rd_wen_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign o_ready      = ready_q;
    assign bus.req      = bus_req_q;
    assign bus.we       = bus_we_q;
    assign bus.addr     = bus_addr_q;
    assign bus.be       = bus_be_q;
    assign bus.wdata    = bus_wdata_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_rd_wen  = wb_rd_wen_q;
    assign o_wb_rd_addr = wb_rd_addr_q;
    assign o_wb_data    = wb_data_q;
    assign o_misalign   = misalign_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed, table-driven bench for exu_lsu with TIMEOUT_CYCLES=4.
//
// Each table entry describes one instruction and the response the bus gives
// to it. Separate hand-written sequences cover:
//   - back-to-back non-memory throughput
//   - a bus timeout, including rvalid arriving in the wrong state
//   - reset while a load is in flight

module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_mem_wen;
    logic        i_mem_ren;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        o_wb_valid;
    logic        o_wb_rd_wen;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_bus_err;

    int n_checks = 0;
    int n_fails  = 0;

    exu_lsu_if bus_if ();

    exu_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mem_wen    (i_mem_wen),
        .i_mem_ren    (i_mem_ren),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_rd_wen     (i_rd_wen),
        .i_rd_addr    (i_rd_addr),
        .bus          (bus_if.master),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd_wen  (o_wb_rd_wen),
        .o_wb_rd_addr (o_wb_rd_addr),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic        rd_wen;
        logic [4:0]  rd_addr;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        exp_bus;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_rd_wen;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[20];

    // Counts the check and prints a FAIL line if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one instruction, plays the bus slave with the delays from the
    // table entry, and checks the bus activity and the write-back beat.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        i_mem_wen    = v.wen;
        i_mem_ren    = v.ren;
        i_funct3     = v.f3;
        i_mem_addr   = v.addr;
        i_mem_wdata  = v.wdata;
        i_alu_result = v.alu;
        i_rd_wen     = v.rd_wen;
        i_rd_addr    = v.rd_addr;
        i_valid      = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        if (!v.exp_bus) begin
            checkOutput($sformatf("v%0d wb_valid", idx), o_wb_valid, 1);
            checkOutput($sformatf("v%0d misalign", idx), o_misalign, v.exp_mis);
            checkOutput($sformatf("v%0d rd_wen", idx), o_wb_rd_wen, v.exp_rd_wen);
            checkOutput($sformatf("v%0d bus_err", idx), o_bus_err, 0);
            checkOutput($sformatf("v%0d bus_req", idx), bus_if.req, 0);
            checkOutput($sformatf("v%0d ready", idx), o_ready, 1);
            if (!v.exp_mis) begin
                checkOutput($sformatf("v%0d wb_data", idx), o_wb_data, v.exp_data);
                checkOutput($sformatf("v%0d rd_addr", idx), o_wb_rd_addr, v.rd_addr);
            end
        end else begin
            for (int k = 0; k <= v.gnt_dly; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput($sformatf("v%0d req c%0d", idx, k), bus_if.req, 1);
                checkOutput($sformatf("v%0d ready c%0d", idx, k), o_ready, 0);
                checkOutput($sformatf("v%0d be c%0d", idx, k), bus_if.be, v.exp_be);
                if (k == 0) begin
                    checkOutput($sformatf("v%0d bus_addr", idx), bus_if.addr, {v.addr[31:2], 2'b00});
                    checkOutput($sformatf("v%0d bus_we", idx), bus_if.we, v.wen);
                    checkOutput($sformatf("v%0d bus_wdata", idx), bus_if.wdata, v.exp_wdata);
                end
            end
            bus_if.gnt = 1'b1;
            @(negedge clk);
            bus_if.gnt = 1'b0;
            checkOutput($sformatf("v%0d req after gnt", idx), bus_if.req, 0);
            if (v.wen) begin
                checkOutput($sformatf("v%0d st wb_valid", idx), o_wb_valid, 1);
                checkOutput($sformatf("v%0d st rd_wen", idx), o_wb_rd_wen, 0);
                checkOutput($sformatf("v%0d st bus_err", idx), o_bus_err, 0);
                checkOutput($sformatf("v%0d st ready", idx), o_ready, 1);
            end else begin
                checkOutput($sformatf("v%0d ld early wb", idx), o_wb_valid, 0);
                checkOutput($sformatf("v%0d ld wait ready", idx), o_ready, 0);
                for (int j = 1; j < v.rv_dly; j++) @(negedge clk);
                bus_if.rvalid = 1'b1;
                bus_if.rdata  = v.rdata;
                @(negedge clk);
                bus_if.rvalid = 1'b0;
                checkOutput($sformatf("v%0d ld wb_valid", idx), o_wb_valid, 1);
                checkOutput($sformatf("v%0d ld wb_data", idx), o_wb_data, v.exp_data);
                checkOutput($sformatf("v%0d ld rd_wen", idx), o_wb_rd_wen, v.exp_rd_wen);
                checkOutput($sformatf("v%0d ld rd_addr", idx), o_wb_rd_addr, v.rd_addr);
                checkOutput($sformatf("v%0d ld bus_err", idx), o_bus_err, 0);
                checkOutput($sformatf("v%0d ld ready", idx), o_ready, 1);
            end
        end
        i_mem_wen = 1'b0;
        i_mem_ren = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d wb pulse end", idx), o_wb_valid, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           wen  ren  f3      addr          wdata         alu           rdw  rd     g  r  rdata         bus  be       exp_wdata     exp_data      erdw mis
        vecs[0]  = '{1'b1,1'b0,3'b000,32'h0000_1003,32'hAABB_CC7F,32'h0,        1'b1,5'd7,  2, 0, 32'h0,        1'b1,4'b1000,32'h7F7F_7F7F,32'h0,        1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,3'b000,32'h0000_2002,32'h0,        32'h0,        1'b1,5'd9,  0, 3, 32'h1280_3456,1'b1,4'b0100,32'h0,        32'hFFFF_FF80,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b1,3'b100,32'h0000_2002,32'h0,        32'h0,        1'b1,5'd10, 1, 1, 32'h1280_3456,1'b1,4'b0100,32'h0,        32'h0000_0080,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b1,3'b001,32'h0000_2002,32'h0,        32'h0,        1'b1,5'd11, 1, 2, 32'h1280_3456,1'b1,4'b1100,32'h0,        32'h0000_1280,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b1,3'b101,32'h0000_2000,32'h0,        32'h0,        1'b1,5'd12, 0, 1, 32'h1280_F456,1'b1,4'b0011,32'h0,        32'h0000_F456,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,3'b001,32'h0000_2000,32'h0,        32'h0,        1'b1,5'd13, 2, 1, 32'h1280_F456,1'b1,4'b0011,32'h0,        32'hFFFF_F456,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b1,3'b010,32'h0000_3004,32'h0,        32'h0,        1'b1,5'd14, 3, 1, 32'hDEAD_BEEF,1'b1,4'b1111,32'h0,        32'hDEAD_BEEF,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b0,3'b001,32'h0000_1002,32'h1234_ABCD,32'h0,        1'b1,5'd15, 1, 0, 32'h0,        1'b1,4'b1100,32'hABCD_ABCD,32'h0,        1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,3'b010,32'h0000_1008,32'hCAFE_F00D,32'h0,        1'b1,5'd16, 0, 0, 32'h0,        1'b1,4'b1111,32'hCAFE_F00D,32'h0,        1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,3'b000,32'h0000_1001,32'h0000_0055,32'h0,        1'b1,5'd17, 0, 0, 32'h0,        1'b1,4'b0010,32'h5555_5555,32'h0,        1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,3'b000,32'h0000_2003,32'h0,        32'h0,        1'b1,5'd0,  0, 1, 32'h7F00_0000,1'b1,4'b1000,32'h0,        32'h0000_007F,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,3'b010,32'h0000_3001,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[12] = '{1'b0,1'b1,3'b001,32'h0000_2001,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[13] = '{1'b1,1'b0,3'b100,32'h0000_1000,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[14] = '{1'b0,1'b1,3'b011,32'h0000_0000,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[15] = '{1'b0,1'b1,3'b010,32'h0000_3002,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[16] = '{1'b0,1'b0,3'b000,32'h0,        32'h0,        32'h0000_1234,1'b1,5'd5,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0000_1234,1'b1,1'b0};
        vecs[17] = '{1'b0,1'b0,3'b111,32'h0000_0003,32'h0,        32'hFFFF_FFFF,1'b0,5'd31, 0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'hFFFF_FFFF,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b1,3'b110,32'h0000_2000,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
        vecs[19] = '{1'b0,1'b1,3'b101,32'h0000_2003,32'h0,        32'h0,        1'b1,5'd4,  0, 0, 32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};

        rst           = 1'b1;
        i_valid       = 1'b0;
        i_mem_wen     = 1'b0;
        i_mem_ren     = 1'b0;
        i_mem_addr    = '0;
        i_mem_wdata   = '0;
        i_funct3      = '0;
        i_alu_result  = '0;
        i_rd_wen      = 1'b0;
        i_rd_addr     = '0;
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst bus_req", bus_if.req, 0);
        checkOutput("rst bus_we", bus_if.we, 0);
        checkOutput("rst bus_addr", bus_if.addr, 0);
        checkOutput("rst bus_be", bus_if.be, 0);
        checkOutput("rst bus_wdata", bus_if.wdata, 0);
        checkOutput("rst wb_valid", o_wb_valid, 0);
        checkOutput("rst wb_rd_wen", o_wb_rd_wen, 0);
        checkOutput("rst wb_rd_addr", o_wb_rd_addr, 0);
        checkOutput("rst wb_data", o_wb_data, 0);
        checkOutput("rst misalign", o_misalign, 0);
        checkOutput("rst bus_err", o_bus_err, 0);
        checkOutput("rst ready", o_ready, 1);
        rst = 1'b0;

        $display("[TB] running %0d table vectors", $size(vecs));
        for (int i = 0; i < $size(vecs); i++) applyStimulus(vecs[i], i);

        // Three back-to-back non-memory ops, one write-back per cycle
        $display("[TB] back-to-back non-memory sequence");
        @(negedge clk);
        i_mem_wen    = 1'b0;
        i_mem_ren    = 1'b0;
        i_alu_result = 32'h0000_1234;
        i_rd_wen     = 1'b1;
        i_rd_addr    = 5'd5;
        i_valid      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) i_valid = 1'b0;
            checkOutput($sformatf("b2b wb_valid %0d", k), o_wb_valid, 1);
            checkOutput($sformatf("b2b wb_data %0d", k), o_wb_data, 32'h0000_1234);
            checkOutput($sformatf("b2b rd_addr %0d", k), o_wb_rd_addr, 5);
            checkOutput($sformatf("b2b rd_wen %0d", k), o_wb_rd_wen, 1);
            checkOutput($sformatf("b2b bus_req %0d", k), bus_if.req, 0);
            checkOutput($sformatf("b2b ready %0d", k), o_ready, 1);
        end
        @(negedge clk);
        checkOutput("b2b pulse end", o_wb_valid, 0);

        // Timeout: no gnt ever arrives, an rvalid during REQ is ignored, and
        // a late rvalid after the abort is ignored as well
        $display("[TB] timeout sequence");
        @(negedge clk);
        i_mem_ren  = 1'b1;
        i_funct3   = 3'b010;
        i_mem_addr = 32'h0000_4000;
        i_rd_wen   = 1'b1;
        i_rd_addr  = 5'd6;
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid   = 1'b0;
        i_mem_ren = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("to req c%0d", k), bus_if.req, 1);
            checkOutput($sformatf("to wb_valid c%0d", k), o_wb_valid, 0);
            bus_if.rvalid = (k == 1);
            bus_if.rdata  = 32'h5A5A_5A5A;
        end
        bus_if.rvalid = 1'b0;
        @(negedge clk);
        checkOutput("to req dropped", bus_if.req, 0);
        checkOutput("to wb_valid", o_wb_valid, 1);
        checkOutput("to bus_err", o_bus_err, 1);
        checkOutput("to rd_wen", o_wb_rd_wen, 0);
        checkOutput("to misalign", o_misalign, 0);
        checkOutput("to ready", o_ready, 1);
        bus_if.rvalid = 1'b1;
        @(negedge clk);
        bus_if.rvalid = 1'b0;
        checkOutput("to late rvalid wb", o_wb_valid, 0);
        checkOutput("to late bus_err", o_bus_err, 0);
        @(negedge clk);
        checkOutput("to late rvalid wb2", o_wb_valid, 0);

        // Reset while waiting for read data
        $display("[TB] reset in WAIT_R sequence");
        @(negedge clk);
        i_mem_ren  = 1'b1;
        i_funct3   = 3'b010;
        i_mem_addr = 32'h0000_2000;
        i_rd_wen   = 1'b1;
        i_rd_addr  = 5'd3;
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid   = 1'b0;
        i_mem_ren = 1'b0;
        checkOutput("rw req", bus_if.req, 1);
        bus_if.gnt = 1'b1;
        @(negedge clk);
        bus_if.gnt = 1'b0;
        checkOutput("rw wait ready", o_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rw req after rst", bus_if.req, 0);
        checkOutput("rw ready after rst", o_ready, 1);
        checkOutput("rw wb after rst", o_wb_valid, 0);
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h1111_1111;
        @(negedge clk);
        bus_if.rvalid = 1'b0;
        checkOutput("rw late rvalid wb", o_wb_valid, 0);
        checkOutput("rw late ready", o_ready, 1);
        @(negedge clk);
        checkOutput("rw late rvalid wb2", o_wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
